icache: RTL
===========

# icache

Direct-mapped, one-word-per-block instruction cache between the datapath fetch stage and the memory controller's instruction port. Hits return in the same cycle. On a miss, a single FSM issues one word read through the `iREN`/`iaddr`/`iwait`/`iload` handshake, fills the block, and serves the hit on the following cycle. One instance per CPU; it is the only driver of `iREN[CPUID]` and `iaddr[CPUID]`.

## Interface

Parameters:
- `SETS`, 16: number of blocks; power of two, 2..256.
- `IDXW`, $clog2(SETS): index width, derived.
- `TAGW`, 30-IDXW: tag width, derived.

Ports:
- `CLK` input 1: clock, rising edge.
- `nRST` input 1: asynchronous active-low reset.
- `imemREN` input 1: datapath fetch request.
- `imemaddr` input 32: fetch byte address; bits [1:0] ignored.
- `ihit` output 1: `imemload` valid this cycle.
- `imemload` output 32: instruction word.
- `flush` input 1: invalidate all blocks (single-cycle pulse or level).
- `iREN` output 1: read request to memory controller.
- `iaddr` output 32: word-aligned read address.
- `iwait` input 1: memory controller busy; read data not yet valid.
- `iload` input 32: read data, valid when `iREN && !iwait`.
- `hit_count` output 32: present only with `ICACHE_STATS_EN`.
- `miss_count` output 32: present only with `ICACHE_STATS_EN`.

## Operation

- Address split: index = `imemaddr[IDXW+1:2]`; tag = `imemaddr[31:IDXW+2]`.
- Storage per set: valid bit, tag, 32-bit data, all flops. Reset clears only the valid bits.
- FSM states: IDLE, FETCH.
  - IDLE: `ihit = imemREN && valid[idx] && tag[idx]==tag`. `imemload = data[idx]` (don't-care when `ihit`=0).
    - On `imemREN && !ihit && !flush`: latch `imemaddr[31:2]` into `maddr`, go to FETCH.
  - FETCH: `iREN`=1, `iaddr = {maddr,2'b00}`, `ihit`=0.
    - On `!iwait`: write `iload` and the tag into set `maddr` index, set valid, go to IDLE.
    - On `iwait`: stay in FETCH indefinitely. No timeout.
- `iREN`=0 and `iaddr`=0 in IDLE.
- The fill uses the latched `maddr`. Changes to `imemaddr` or deassertion of `imemREN` during FETCH do not abort or redirect the fill. The fill completes; the new address is evaluated in IDLE next cycle.
- `flush`:
  - Clears every valid bit on the next edge.
  - Forces `ihit`=0 in the same cycle.
  - In FETCH, the state returns to IDLE next edge and the in-flight fill is discarded, even if `!iwait` that cycle. `flush` wins over a simultaneous fill.
- Outputs during any cycle where `ihit`=0: `imemload` is don't-care.

## Timing

- Reset (`nRST`=0, asynchronous):
  - State IDLE, all valid=0, `maddr`=0.
  - `ihit`=0, `iREN`=0, `iaddr`=0, `imemload`=0, counters=0.
  - Reset mid-FETCH drops `iREN` immediately (asynchronous) and nothing is written.
- Hit latency: 0 cycles (combinational from `imemaddr`).
- Miss latency: cycle 0 detect; cycle 1 onward `iREN`=1. If `iwait` deasserts in cycle N, the block is written at the end of N and `ihit`=1 in cycle N+1 (given the same `imemaddr`). Minimum miss penalty is 2 cycles.
- No combinational path from `iwait` or `iload` to `ihit` or `imemload`.
- Back-to-back misses: the IDLE cycle between fills is mandatory; `iREN` drops for at least one cycle between requests.

## Configuration

- `ICACHE_STATS_EN`
  - Defined:
    - Adds `hit_count` and `miss_count` ports.
    - `hit_count` increments on each cycle with `ihit`=1.
    - `miss_count` increments on each IDLE→FETCH transition.
    - Both are 32-bit, wrap at 2^32-1 → 0, reset to 0, and are unaffected by `flush`.
  - Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan

- Reset then cold miss: `imemREN`=1, `imemaddr`=0x00000040, `iwait`=1 for 3 cycles then 0 with `iload`=0x8C220004.
  - Required: `iREN`=1 and `iaddr`=0x00000040 in cycles 1–4.
  - Required: `ihit`=1 and `imemload`=0x8C220004 in cycle 5.
  - Required: `miss_count`=1.
- Hit: after the above, `imemaddr`=0x00000042 (low bits ignored) → `ihit`=1 in the same cycle, `iREN`=0.
- Conflict eviction: fill 0x00000040, then request 0x00000080 (same index, SETS=16) → miss and refill. A subsequent request to 0x00000040 misses again.
- Redirect mid-fetch: miss on 0x00000100, change `imemaddr` to 0x00000200 while `iwait`=1.
  - Required: `iaddr` stays 0x00000100 until the fill completes.
  - Required: the next cycle in IDLE misses on 0x00000200.
- Flush with simultaneous fill: in FETCH, assert `flush` in the same cycle as `iwait`=0.
  - Required: next cycle state is IDLE, all valid=0, and the old address misses.
- Asynchronous reset mid-FETCH: pull `nRST` low between clock edges.
  - Required: `iREN`=0 immediately.
  - Required: after release, the previously hit address misses.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a single-miss fill FSM.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 30 - IDXW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [SETS-1:0]     r_valid;
    logic [TAGW-1:0]     r_tag  [SETS];
    logic [31:0]         r_data [SETS];
    logic [29:0]         r_maddr;

    logic [IDXW-1:0]     w_idx;
    logic [TAGW-1:0]     w_tag;
    logic [IDXW-1:0]     w_midx;
    logic [TAGW-1:0]     w_mtag;
    logic                w_match;
    logic                w_miss_start;
    logic                w_fill;
    logic [1:0]          w_unused_lsb;

    assign w_idx        = imemaddr[IDXW+1:2];
    assign w_tag        = imemaddr[31:IDXW+2];
    assign w_midx       = r_maddr[IDXW-1:0];
    assign w_mtag       = r_maddr[29:IDXW];
    assign w_unused_lsb = imemaddr[1:0];

    assign w_match      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss_start = (r_state == S_IDLE) && imemREN && !w_match && !flush;
    // flush beats a fill completing in the same cycle
    assign w_fill       = (r_state == S_FETCH) && !iwait && !flush;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_miss_start)      w_next_state = S_FETCH;
            S_FETCH: if (flush || !iwait)   w_next_state = S_IDLE;
            default:                        w_next_state = S_IDLE;
        endcase
    end

    // Output logic: hits are combinational from imemaddr, memory port from state
    always_comb begin
        ihit     = 1'b0;
        imemload = 32'h0;
        iREN     = 1'b0;
        iaddr    = 32'h0;
        case (r_state)
            S_IDLE: begin
                ihit = imemREN && w_match && !flush;
                if (ihit) imemload = r_data[w_idx];
            end
            S_FETCH: begin
                iREN  = 1'b1;
                iaddr = {r_maddr, 2'b00};
            end
            default: ;
        endcase
    end

    // Miss address latch and valid bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_maddr <= 30'h0;
            r_valid <= '0;
        end else begin
            if (w_miss_start) r_maddr <= imemaddr[31:2];
            if (flush)        r_valid <= '0;
            else if (w_fill)  r_valid[w_midx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_midx]  <= w_mtag;
            r_data[w_midx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= 32'h0;
            r_miss_count <= 32'h0;
        end else begin
            if (ihit)         r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss_start) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
